// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared types and default widths for the data memory with
//                store buffer. Holds the default data width, the byte-enable
//                width and the store-buffer entry record.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

  // Default data word width in bits (multiple of 8).
  localparam int DATA_W = 32;
  // Byte enables per data word.
  localparam int BE_W   = DATA_W / 8;
  // Word index carried in each entry: byte address bits [31:2], already
  // reduced modulo the memory depth so that aliasing addresses compare equal.
  localparam int IDX_W  = 30;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_forward_merge.sv
`default_nettype none
// ============================================================================
//  Module      : sb_forward_merge
//  Description : Combinational load-forwarding merge. Each byte of the result
//                comes from the youngest valid buffer entry whose word index
//                matches and whose enable bit for that byte is set; bytes
//                with no such entry come from the memory word.
//  Ports       : entries  - store-buffer storage (all slots)
//                head     - slot index of the oldest entry
//                count    - number of valid entries
//                idx      - word index of the load
//                mem_word - memory contents at idx
//                merged   - forwarded load result
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_forward_merge
  import data_mem_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  sb_entry_t                     entries [SB_DEPTH],
  input  logic [$clog2(SB_DEPTH)-1:0]   head,
  input  logic [$clog2(SB_DEPTH):0]     count,
  input  logic [IDX_W-1:0]              idx,
  input  logic [DATA_W-1:0]             mem_word,
  output logic [DATA_W-1:0]             merged
);

  localparam int PTR_W = $clog2(SB_DEPTH);

  logic [PTR_W-1:0] w_slot;

  // Walk from oldest to youngest; later matches overwrite earlier ones, so
  // the youngest matching entry wins independently for every byte.
  always_comb begin
    merged = mem_word;
    w_slot = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_slot = head + PTR_W'(k);
      if ((k < int'(count)) && (entries[w_slot].idx == idx)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (entries[w_slot].be[b]) begin
            merged[b*8 +: 8] = entries[w_slot].data[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_store_buffer
//  Description : Word-addressed data memory fronted by a FIFO store buffer.
//                Stores are queued and drained into memory on cycles with no
//                load; loads have priority, complete in one cycle and see
//                buffered stores through per-byte forwarding.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                st_valid/st_ready     - store handshake
//                st_addr/st_data/st_be - store byte address, data, enables
//                ld_valid/ld_addr      - load request (always accepted)
//                ld_data/ld_done       - registered load result and pulse
//                sb_empty              - store buffer holds no entries
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_store_buffer
  import data_mem_pkg::*;
#(
  parameter int DATA_W   = data_mem_pkg::DATA_W,
  parameter int DEPTH    = 256,
  parameter int SB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [31:0]         st_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W/8-1:0] st_be,
  input  logic                ld_valid,
  input  logic [31:0]         ld_addr,
  output logic [DATA_W-1:0]   ld_data,
  output logic                ld_done,
  output logic                sb_empty
);

  localparam int PTR_W  = $clog2(SB_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int NBYTES = DATA_W / 8;
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(DEPTH - 1);

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  sb_entry_t         r_entries [SB_DEPTH];
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ld_data;
  logic              r_ld_done;

  logic [IDX_W-1:0]  w_st_idx;
  logic [IDX_W-1:0]  w_ld_idx;
  logic              w_enq;
  logic              w_drain;
  sb_entry_t         w_head_entry;
  logic [DATA_W-1:0] w_mem_rd;
  logic [DATA_W-1:0] w_merged;

  // Sub-word position is carried by the byte enables alone.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // Indices are reduced modulo DEPTH up front so aliasing addresses match
  // during forwarding exactly as they would in memory.
  assign w_st_idx = st_addr[31:2] & IDX_MASK;
  assign w_ld_idx = ld_addr[31:2] & IDX_MASK;

  // Readiness depends only on the registered count: a drain this cycle
  // frees a slot for next cycle, not this one.
  assign st_ready = (r_count < CNT_W'(SB_DEPTH));
  assign sb_empty = (r_count == '0);
  assign w_enq    = st_valid && st_ready;
  // Loads own the memory port; the drain waits for a load-free cycle.
  assign w_drain  = (r_count != '0) && !ld_valid;

  assign w_head_entry = r_entries[r_head];
  assign w_mem_rd     = r_mem[w_ld_idx[AW-1:0]];

  sb_forward_merge #(
    .SB_DEPTH (SB_DEPTH)
  ) u_merge (
    .entries  (r_entries),
    .head     (r_head),
    .count    (r_count),
    .idx      (w_ld_idx),
    .mem_word (w_mem_rd),
    .merged   (w_merged)
  );

  // Control state: pointers, occupancy and load response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_ld_data <= '0;
      r_ld_done <= 1'b0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_head <= r_head + 1'b1;
      end
      if (w_enq && !w_drain) begin
        r_count <= r_count + 1'b1;
      end else if (w_drain && !w_enq) begin
        r_count <= r_count - 1'b1;
      end
      r_ld_done <= ld_valid;
      if (ld_valid) begin
        r_ld_data <= w_merged;
      end
    end
  end

  // Storage: buffer slots and memory array carry no reset. Reset blocks
  // both writes so pending entries are discarded rather than committed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_enq) begin
        r_entries[r_tail] <= '{idx: w_st_idx, data: st_data, be: st_be};
      end
      if (w_drain) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (w_head_entry.be[b]) begin
            r_mem[w_head_entry.idx[AW-1:0]][b*8 +: 8] <= w_head_entry.data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign ld_data = r_ld_data;
  assign ld_done = r_ld_done;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_store_buffer
//  Description : Directed self-checking bench for data_mem_store_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        sb_empty;

  int n_checks = 0;
  int n_fails  = 0;

  data_mem_store_buffer #(
    .DATA_W   (32),
    .DEPTH    (256),
    .SB_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_be    (st_be),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_done  (ld_done),
    .sb_empty (sb_empty)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_ld_done",  32'(ld_done),  32'd0);
    chk("rst_ld_data",  ld_data,       32'h0);

    // Basic store, drain, load.
    store(32'h10, 32'hDEADBEEF, 4'b1111);
    tick();
    st_valid = 1'b0;
    chk("st1_not_empty", 32'(sb_empty), 32'd0);
    tick();
    chk("st1_drained", 32'(sb_empty), 32'd1);
    tick(); tick();
    ld_valid = 1'b1; ld_addr = 32'h10;
    tick();
    ld_valid = 1'b0;
    chk("ld1_done", 32'(ld_done), 32'd1);
    chk("ld1_data", ld_data, 32'hDEADBEEF);
    tick();
    chk("ld1_done_pulse", 32'(ld_done), 32'd0);
    chk("ld1_hold", ld_data, 32'hDEADBEEF);

    // Partial-byte forwarding over a memory word.
    store(32'h20, 32'h11223344, 4'b1111);
    tick();
    st_valid = 1'b0;
    tick(); tick();
    ld_valid = 1'b1; ld_addr = 32'h20;
    store(32'h20, 32'hAABBCCDD, 4'b0011);
    tick();
    st_valid = 1'b0;
    chk("fwd_same_cycle_not_fwd", ld_data, 32'h11223344);
    tick();
    chk("fwd_partial", ld_data, 32'h1122CCDD);
    chk("fwd_done_b2b", 32'(ld_done), 32'd1);
    chk("fwd_sb_not_empty", 32'(sb_empty), 32'd0);
    ld_valid = 1'b0;
    tick();
    chk("fwd_drained", 32'(sb_empty), 32'd1);
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    chk("fwd_mem_merged", ld_data, 32'h1122CCDD);

    // Youngest entry wins.
    ld_valid = 1'b1; ld_addr = 32'h30;
    store(32'h30, 32'h000000FF, 4'b0001);
    tick();
    store(32'h30, 32'h000000EE, 4'b0001);
    tick();
    st_valid = 1'b0;
    chk("young_one_entry", 32'(ld_data[7:0]), 32'hFF);
    tick();
    chk("young_wins", 32'(ld_data[7:0]), 32'hEE);
    ld_valid = 1'b0;
    tick(); tick();
    chk("young_drained", 32'(sb_empty), 32'd1);

    // Full buffer back-pressure and wrap.
    ld_valid = 1'b1; ld_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      store(32'h40 + 32'(i * 4), 32'h5000_0000 + 32'(i), 4'b1111);
      chk("full_ready_before", 32'(st_ready), 32'd1);
      tick();
    end
    chk("full_ready_low", 32'(st_ready), 32'd0);
    store(32'h50, 32'h5000_0004, 4'b1111);
    tick();
    chk("full_still_low", 32'(st_ready), 32'd0);
    ld_valid = 1'b0;
    tick();
    chk("full_ready_after_drain", 32'(st_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    tick(); tick(); tick();
    chk("full_all_drained", 32'(sb_empty), 32'd1);
    ld_valid = 1'b1; ld_addr = 32'h50;
    tick();
    chk("full_fifth_stored", ld_data, 32'h5000_0004);
    ld_addr = 32'h40;
    tick();
    ld_valid = 1'b0;
    chk("full_first_stored", ld_data, 32'h5000_0000);

    // Reset discards pending entries.
    store(32'h60, 32'h55667788, 4'b1111);
    tick();
    st_valid = 1'b0;
    tick();
    ld_valid = 1'b1; ld_addr = 32'h60;
    for (int i = 0; i < 3; i++) begin
      store(32'h60, 32'h9999_0000 + 32'(i), 4'b1111);
      tick();
    end
    chk("rstmid_fwd_before", ld_data, 32'h9999_0001);
    rst = 1'b1;
    tick();
    rst = 1'b0; st_valid = 1'b0; ld_valid = 1'b0;
    chk("rstmid_sb_empty", 32'(sb_empty), 32'd1);
    chk("rstmid_ld_data", ld_data, 32'h0);
    chk("rstmid_ld_done", 32'(ld_done), 32'd0);
    chk("rstmid_st_ready", 32'(st_ready), 32'd1);
    tick(); tick();
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    chk("rstmid_mem_kept", ld_data, 32'h55667788);

    // Address aliasing modulo DEPTH.
    ld_valid = 1'b1; ld_addr = 32'h0;
    store(32'h400, 32'hCAFEF00D, 4'b1111);
    tick();
    st_valid = 1'b0;
    tick();
    chk("alias_fwd", ld_data, 32'hCAFEF00D);
    ld_valid = 1'b0;
    tick(); tick();
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    chk("alias_mem", ld_data, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
